// File: rtl/forwarding_hazard_unit_if.sv
// Decode-side bundle of the forwarding/hazard unit: decode operand info in,
// ALU operand select codes and the pipeline stall back out.
interface forwarding_hazard_unit_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_use_src1;
  logic                  id_use_src2;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [1:0]            alu_input1_sel;
  logic [1:0]            alu_input2_sel;
  logic                  stall;

  modport master (
    output id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
    output id_dst, id_reg_write, id_mem_read, flush,
    input  alu_input1_sel, alu_input2_sel, stall
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
    input  id_dst, id_reg_write, id_mem_read, flush,
    output alu_input1_sel, alu_input2_sel, stall
  );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Decode-to-execute hazard unit: tracks the two producers ahead of decode, emits
// registered ALU forwarding selects and stalls decode for load-use dependencies.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W      = 3,
  parameter int LOAD_USE_STALLS = 1
) (
  input logic                     clk,
  input logic                     rst,
  forwarding_hazard_unit_if.slave fhu
);
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  localparam logic [1:0] SEL_REG  = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);

  state_t                r_state;
  logic [1:0]            r_cnt;
  logic                  r_ex_v;
  logic [REG_ADDR_W-1:0] r_ex_dst;
  logic                  r_ex_load;
  logic                  r_mem_v;
  logic [REG_ADDR_W-1:0] r_mem_dst;
  logic [1:0]            r_sel1;
  logic [1:0]            r_sel2;

  logic [2:0] w_res1;
  logic [2:0] w_res2;
  logic       w_hazard;
  logic       w_stall;

  // Returns {load_use_hazard, select_code}; the execute-stage producer shadows the memory-stage one.
  function automatic logic [2:0] resolve(
    input logic                  valid,
    input logic                  use_src,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  ex_v,
    input logic [REG_ADDR_W-1:0] ex_dst,
    input logic                  ex_load,
    input logic                  mem_v,
    input logic [REG_ADDR_W-1:0] mem_dst
  );
    logic [2:0] res;
    if (!(valid && use_src)) begin
      res = {1'b0, SEL_REG};
    end else if (ex_v && (ex_dst == src)) begin
      res = ex_load ? {1'b1, SEL_REG} : {1'b0, SEL_ALU};
    end else if (mem_v && (mem_dst == src)) begin
      res = {1'b0, SEL_MEM};
    end else begin
      res = {1'b0, SEL_REG};
    end
    return res;
  endfunction

  // Per-operand match of the decode instruction against the in-flight producer tags.
  always_comb begin
    w_res1   = resolve(fhu.id_valid, fhu.id_use_src1, fhu.id_src1,
                       r_ex_v, r_ex_dst, r_ex_load, r_mem_v, r_mem_dst);
    w_res2   = resolve(fhu.id_valid, fhu.id_use_src2, fhu.id_src2,
                       r_ex_v, r_ex_dst, r_ex_load, r_mem_v, r_mem_dst);
    w_hazard = w_res1[2] | w_res2[2];
  end

  // Stall is combinational so the PC and IF/ID hold in the same cycle the hazard is seen.
  always_comb begin
    w_stall = 1'b0;
    if (fhu.flush) begin
      w_stall = 1'b0;
    end else if (r_state == ST_STALL) begin
      w_stall = 1'b1;
    end else begin
      w_stall = w_hazard;
    end
  end

  // Producer tags, bubble insertion, stall counter and registered select codes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= 2'd0;
      r_ex_v    <= 1'b0;
      r_ex_dst  <= '0;
      r_ex_load <= 1'b0;
      r_mem_v   <= 1'b0;
      r_mem_dst <= '0;
      r_sel1    <= SEL_REG;
      r_sel2    <= SEL_REG;
    end else begin
      r_mem_v   <= r_ex_v;
      r_mem_dst <= r_ex_dst;
      if (fhu.flush) begin
        r_state <= ST_RUN;
        r_cnt   <= 2'd0;
        r_ex_v  <= 1'b0;
        r_sel1  <= SEL_ZERO;
        r_sel2  <= SEL_ZERO;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_hazard) begin
              r_ex_v  <= 1'b0;
              r_sel1  <= SEL_ZERO;
              r_sel2  <= SEL_ZERO;
              r_cnt   <= CNT_INIT;
              r_state <= (CNT_INIT != 2'd0) ? ST_STALL : ST_RUN;
            end else begin
              r_ex_v    <= fhu.id_valid & fhu.id_reg_write;
              r_ex_dst  <= fhu.id_dst;
              r_ex_load <= fhu.id_mem_read;
              r_sel1    <= w_res1[1:0];
              r_sel2    <= w_res2[1:0];
            end
          end
          ST_STALL: begin
            r_ex_v <= 1'b0;
            r_sel1 <= SEL_ZERO;
            r_sel2 <= SEL_ZERO;
            if (r_cnt <= 2'd1) begin
              r_cnt   <= 2'd0;
              r_state <= ST_RUN;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
          default: begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
            r_ex_v  <= 1'b0;
            r_sel1  <= SEL_ZERO;
            r_sel2  <= SEL_ZERO;
          end
        endcase
      end
    end
  end

  assign fhu.alu_input1_sel = r_sel1;
  assign fhu.alu_input2_sel = r_sel2;
  assign fhu.stall          = w_stall;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: one-stall and two-stall instances share stimulus and
// are checked against a producer-list model, directed scenarios first, then random traffic.
module tb_forwarding_hazard_unit;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forwarding_hazard_unit_if #(.REG_ADDR_W(AW)) if0 ();
  forwarding_hazard_unit_if #(.REG_ADDR_W(AW)) if1 ();

  forwarding_hazard_unit #(.REG_ADDR_W(AW), .LOAD_USE_STALLS(1)) u_dut0 (
    .clk(clk), .rst(rst), .fhu(if0.slave));
  forwarding_hazard_unit #(.REG_ADDR_W(AW), .LOAD_USE_STALLS(2)) u_dut1 (
    .clk(clk), .rst(rst), .fhu(if1.slave));

  int n_vec = 0;
  int n_err = 0;

  int in_rst = 1, in_flush = 0, in_valid = 0, in_s1 = 0, in_s2 = 0;
  int in_u1 = 0, in_u2 = 0, in_dst = 0, in_rw = 0, in_mr = 0;

  // Model: the two producers ahead of decode plus remaining bubble count, per instance.
  int lus[2] = '{1, 2};
  int m_ex_v[2], m_ex_dst[2], m_ex_ld[2], m_mem_v[2], m_mem_dst[2];
  int m_left[2], m_sel1[2], m_sel2[2];
  int obs_stall[2];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0/1/2 are select codes, 4 means load-use hazard.
  function automatic int op_code(input int k, input int use_s, input int src);
    if (in_valid == 0 || use_s == 0) return 0;
    if (m_ex_v[k] != 0 && m_ex_dst[k] == src) return (m_ex_ld[k] != 0) ? 4 : 1;
    if (m_mem_v[k] != 0 && m_mem_dst[k] == src) return 2;
    return 0;
  endfunction

  task automatic drive();
    rst = (in_rst != 0);
    if0.flush = (in_flush != 0);          if1.flush = (in_flush != 0);
    if0.id_valid = (in_valid != 0);       if1.id_valid = (in_valid != 0);
    if0.id_src1 = AW'(in_s1);             if1.id_src1 = AW'(in_s1);
    if0.id_src2 = AW'(in_s2);             if1.id_src2 = AW'(in_s2);
    if0.id_use_src1 = (in_u1 != 0);       if1.id_use_src1 = (in_u1 != 0);
    if0.id_use_src2 = (in_u2 != 0);       if1.id_use_src2 = (in_u2 != 0);
    if0.id_dst = AW'(in_dst);             if1.id_dst = AW'(in_dst);
    if0.id_reg_write = (in_rw != 0);      if1.id_reg_write = (in_rw != 0);
    if0.id_mem_read = (in_mr != 0);       if1.id_mem_read = (in_mr != 0);
  endtask

  // One clock: check stall before the edge, advance the model, check selects after it.
  task automatic step();
    int c1[2], c2[2], haz[2], exp_stall;
    drive();
    #1;
    obs_stall[0] = int'(if0.stall);
    obs_stall[1] = int'(if1.stall);
    for (int k = 0; k < 2; k++) begin
      c1[k] = op_code(k, in_u1, in_s1);
      c2[k] = op_code(k, in_u2, in_s2);
      haz[k] = (c1[k] == 4 || c2[k] == 4) ? 1 : 0;
      if (in_flush != 0) exp_stall = 0;
      else if (m_left[k] > 0) exp_stall = 1;
      else exp_stall = haz[k];
      check_val(k == 0 ? "stall0" : "stall1", obs_stall[k], exp_stall);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (in_rst == 0) begin
        m_ex_v[k] = 0; m_mem_v[k] = 0; m_left[k] = 0; m_sel1[k] = 0; m_sel2[k] = 0;
      end else begin
        m_mem_v[k] = m_ex_v[k];
        m_mem_dst[k] = m_ex_dst[k];
        if (in_flush != 0) begin
          m_sel1[k] = 3; m_sel2[k] = 3; m_ex_v[k] = 0; m_left[k] = 0;
        end else if (m_left[k] > 0) begin
          m_sel1[k] = 3; m_sel2[k] = 3; m_ex_v[k] = 0; m_left[k]--;
        end else if (haz[k] != 0) begin
          m_sel1[k] = 3; m_sel2[k] = 3; m_ex_v[k] = 0; m_left[k] = lus[k] - 1;
        end else begin
          m_sel1[k] = c1[k]; m_sel2[k] = c2[k];
          m_ex_v[k] = (in_valid != 0 && in_rw != 0) ? 1 : 0;
          m_ex_dst[k] = in_dst;
          m_ex_ld[k] = in_mr;
        end
      end
    end
    #1;
    check_val("sel1_0", int'(if0.alu_input1_sel), m_sel1[0]);
    check_val("sel2_0", int'(if0.alu_input2_sel), m_sel2[0]);
    check_val("sel1_1", int'(if1.alu_input1_sel), m_sel1[1]);
    check_val("sel2_1", int'(if1.alu_input2_sel), m_sel2[1]);
    @(negedge clk);
  endtask

  task automatic ins(input int v, input int s1, input int s2, input int u1, input int u2,
                     input int dst, input int rw, input int mr);
    in_valid = v; in_s1 = s1; in_s2 = s2; in_u1 = u1; in_u2 = u2;
    in_dst = dst; in_rw = rw; in_mr = mr; in_flush = 0; in_rst = 1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      ins(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ex_v[k] = 0; m_ex_dst[k] = 0; m_ex_ld[k] = 0; m_mem_v[k] = 0; m_mem_dst[k] = 0;
      m_left[k] = 0; m_sel1[k] = 0; m_sel2[k] = 0;
    end
    in_rst = 0;
    drive();
    @(negedge clk);
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    in_rst = 0;
    step();
    check_val("rst_sel1", int'(if0.alu_input1_sel), 0);
    check_val("rst_stall", obs_stall[1], 0);

    // ADD R1 ; SUB R2,R1,R3 -> forward from ALU on operand 1
    nops(2);
    ins(1, 2, 3, 1, 1, 1, 1, 0); step();
    ins(1, 1, 3, 1, 1, 2, 1, 0); step();
    check_val("t1_sel1", int'(if0.alu_input1_sel), 1);
    check_val("t1_sel2", int'(if0.alu_input2_sel), 0);
    check_val("t1_stall", obs_stall[0], 0);

    // ADD R1 ; NOP ; AND R4,R1,R1 -> both from mem stage
    nops(2);
    ins(1, 2, 3, 1, 1, 1, 1, 0); step();
    nops(1);
    ins(1, 1, 1, 1, 1, 4, 1, 0); step();
    check_val("t2_sel1", int'(if1.alu_input1_sel), 2);
    check_val("t2_sel2", int'(if1.alu_input2_sel), 2);

    // ADD R1 ; ADD R1 ; OR R5,R1,R6 -> newest producer wins
    nops(2);
    ins(1, 2, 3, 1, 1, 1, 1, 0); step();
    ins(1, 2, 3, 1, 1, 1, 1, 0); step();
    ins(1, 1, 6, 1, 1, 5, 1, 0); step();
    check_val("t3_sel1", int'(if0.alu_input1_sel), 1);

    // LDD R2 ; ADD R3,R2,R2 held in decode while stalled
    nops(2);
    ins(1, 0, 0, 0, 0, 2, 1, 1); step();
    ins(1, 2, 2, 1, 1, 3, 1, 0); step();
    check_val("t4_stall_a", obs_stall[0], 1);
    check_val("t4_bubble", int'(if0.alu_input1_sel), 3);
    step();
    check_val("t4_stall_b", obs_stall[0], 0);
    check_val("t4_sel1", int'(if0.alu_input1_sel), 2);
    check_val("t4_sel2", int'(if0.alu_input2_sel), 2);
    check_val("t5_stall_b", obs_stall[1], 1);
    step();
    check_val("t5_stall_c", obs_stall[1], 0);
    check_val("t5_sel1", int'(if1.alu_input1_sel), 0);

    // Flush in the first load-use stall cycle
    nops(2);
    ins(1, 0, 0, 0, 0, 2, 1, 1); step();
    ins(1, 2, 2, 1, 1, 3, 1, 0); in_flush = 1; step();
    check_val("t5f_stall", obs_stall[1], 0);
    check_val("t5f_sel", int'(if1.alu_input1_sel), 3);
    in_flush = 0; step();

    // Flush during the STALL state of the two-bubble instance
    nops(2);
    ins(1, 0, 0, 0, 0, 2, 1, 1); step();
    ins(1, 2, 2, 1, 1, 3, 1, 0); step();
    in_flush = 1; step();
    check_val("t5g_stall", obs_stall[1], 0);
    in_flush = 0; step();

    // Reset while stalled
    nops(2);
    ins(1, 0, 0, 0, 0, 2, 1, 1); step();
    ins(1, 2, 2, 1, 1, 3, 1, 0); step();
    in_rst = 0; step();
    check_val("t6_sel1", int'(if1.alu_input1_sel), 0);
    in_rst = 1; step();
    check_val("t6_stall", obs_stall[1], 0);
    check_val("t6_code", int'(if1.alu_input1_sel), 0);

    // Random traffic; small register range keeps dependencies frequent
    for (int i = 0; i < 1500; i++) begin
      ins(($urandom_range(0, 9) != 0) ? 1 : 0,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 1),
          ($urandom_range(0, 2) == 0) ? 1 : 0);
      in_flush = ($urandom_range(0, 19) == 0) ? 1 : 0;
      in_rst = ($urandom_range(0, 99) == 0) ? 0 : 1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
